wb_stage_pipe: RTL

//  Registered write-back stage for the pipelined/multicycle RV32I core.

---
 rtl/wb_stage_pipe.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_stage_pipe.sv
// Registered RV32I write-back stage: five-source select, load alignment/extension,
// variable-latency load wait, flush, and a forwarding view of the register-file write.
module wb_stage_pipe #(
    parameter int XLEN    = 32,
    parameter int RA_W    = 5,
    parameter int WBSEL_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WBSEL_W-1:0] in_wb_sel,
    input  logic               in_reg_write,
    input  logic [RA_W-1:0]    in_rd,
    input  logic [2:0]         in_funct3,
    input  logic [1:0]         in_addr_lo,
    input  logic [XLEN-1:0]    in_alu_result,
    input  logic [XLEN-1:0]    in_pc_plus4,
    input  logic [XLEN-1:0]    in_imm,
    input  logic [XLEN-1:0]    in_csr_rdata,
    input  logic               mem_rvalid,
    input  logic [31:0]        mem_rdata,
    input  logic               flush,
    output logic               rf_we,
    output logic [RA_W-1:0]    rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic               busy,
    output logic [RA_W-1:0]    pend_rd,
    output logic               fwd_valid,
    output logic [RA_W-1:0]    fwd_rd,
    output logic [XLEN-1:0]    fwd_data
);

    localparam logic [WBSEL_W-1:0] SEL_ALU = WBSEL_W'(0);
    localparam logic [WBSEL_W-1:0] SEL_MEM = WBSEL_W'(1);
    localparam logic [WBSEL_W-1:0] SEL_PC4 = WBSEL_W'(2);
    localparam logic [WBSEL_W-1:0] SEL_IMM = WBSEL_W'(3);
    localparam logic [WBSEL_W-1:0] SEL_CSR = WBSEL_W'(4);

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic              r_rf_we;
    logic [RA_W-1:0]   r_rf_waddr;
    logic [XLEN-1:0]   r_rf_wdata;

    logic              r_ld_we;
    logic [RA_W-1:0]   r_ld_rd;
    logic [2:0]        r_ld_funct3;
    logic [1:0]        r_ld_addr_lo;

    logic              w_accept;
    logic              w_is_mem;
    logic              w_complete_now;
    logic              w_load_done;
    logic [2:0]        w_al_funct3;
    logic [1:0]        w_al_addr_lo;
    logic [7:0]        w_bytes [4];
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [XLEN-1:0]   w_aligned;
    logic [XLEN-1:0]   w_sel_data;

    assign w_is_mem       = (in_wb_sel == SEL_MEM);
    assign w_accept       = (r_state == ST_IDLE) && in_valid && !flush;
    assign w_complete_now = w_accept && (!w_is_mem || mem_rvalid);
    assign w_load_done    = (r_state == ST_LOAD_WAIT) && mem_rvalid && !flush;

    // ------------------------------------------------------------------
    // FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_mem && !mem_rvalid) begin
                    w_state_next = ST_LOAD_WAIT;
                end
            end
            ST_LOAD_WAIT: begin
                if (flush || mem_rvalid) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        pend_rd  = '0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_LOAD_WAIT: begin
                busy    = 1'b1;
                pend_rd = r_ld_rd;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load alignment: one aligner serves both the 0-wait path (live
    // control) and the waited path (latched control).
    // ------------------------------------------------------------------
    assign w_al_funct3  = (r_state == ST_LOAD_WAIT) ? r_ld_funct3  : in_funct3;
    assign w_al_addr_lo = (r_state == ST_LOAD_WAIT) ? r_ld_addr_lo : in_addr_lo;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign w_bytes[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    assign w_byte = w_bytes[w_al_addr_lo];
    assign w_half = w_al_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        w_aligned = XLEN'($signed(mem_rdata));
        case (w_al_funct3)
            3'b000:  w_aligned = XLEN'($signed(w_byte));
            3'b100:  w_aligned = XLEN'(w_byte);
            3'b001:  w_aligned = XLEN'($signed(w_half));
            3'b101:  w_aligned = XLEN'(w_half);
            default: w_aligned = XLEN'($signed(mem_rdata));
        endcase
    end

    always_comb begin
        w_sel_data = in_alu_result;
        case (in_wb_sel)
            SEL_ALU: w_sel_data = in_alu_result;
            SEL_MEM: w_sel_data = w_aligned;
            SEL_PC4: w_sel_data = in_pc_plus4;
            SEL_IMM: w_sel_data = in_imm;
            SEL_CSR: w_sel_data = in_csr_rdata;
            default: w_sel_data = in_alu_result;
        endcase
    end

    // ------------------------------------------------------------------
    // Latched control of an outstanding load
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ld_we      <= 1'b0;
            r_ld_rd      <= '0;
            r_ld_funct3  <= '0;
            r_ld_addr_lo <= '0;
        end else if (w_accept && w_is_mem && !mem_rvalid) begin
            r_ld_we      <= in_reg_write;
            r_ld_rd      <= in_rd;
            r_ld_funct3  <= in_funct3;
            r_ld_addr_lo <= in_addr_lo;
        end
    end

    // ------------------------------------------------------------------
    // Register-file write port; rf_we is a single-cycle pulse, address
    // and data hold between writes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= 1'b0;
            if (w_complete_now) begin
                r_rf_we    <= in_reg_write && (in_rd != '0);
                r_rf_waddr <= in_rd;
                r_rf_wdata <= w_sel_data;
            end else if (w_load_done) begin
                r_rf_we    <= r_ld_we && (r_ld_rd != '0);
                r_rf_waddr <= r_ld_rd;
                r_rf_wdata <= w_aligned;
            end
        end
    end

    assign rf_we     = r_rf_we;
    assign rf_waddr  = r_rf_waddr;
    assign rf_wdata  = r_rf_wdata;
    assign fwd_valid = r_rf_we;
    assign fwd_rd    = r_rf_waddr;
    assign fwd_data  = r_rf_wdata;

endmodule
